// File: rtl/iot_pkg.sv
// Shared types and constants for the IOTDF upstream serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iot_pkg;

    localparam int WORD_W         = 128;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 16;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    localparam logic [2:0] F_MAX     = 3'd1;
    localparam logic [2:0] F_MIN     = 3'd2;
    localparam logic [2:0] F_AVG     = 3'd3;
    localparam logic [2:0] F_EXTRACT = 3'd4;
    localparam logic [2:0] F_EXCLUDE = 3'd5;
    localparam logic [2:0] F_PEAKMAX = 3'd6;
    localparam logic [2:0] F_PEAKMIN = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_DONE = 2'd2
    } tx_state_t;

    // Byte idx 0 is the most significant byte of the word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                     input logic [IDX_W-1:0]  idx);
        logic [IDX_W+2:0] sh;
        sh = {~idx, 3'b000};
        return BYTE_W'(w >> sh);
    endfunction

endpackage

// File: rtl/iot_word_fifo.sv
// Generic DEPTH x W word FIFO exposing the head and the word behind it.
// Latency: a pushed word is visible at head one cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module iot_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         has_two,
    output logic [W-1:0] head,
    output logic [W-1:0] head_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_nx;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + 1'b1;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign has_two   = (count > ONE_CNT);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_nx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/iot_tx_serializer.sv
// Buffers 128-bit words and streams them MSB-byte-first to the IOTDF core, one frame of NUM_WORDS per start.
// Latency: start at edge E0, first byte on the bus after E1; one byte per cycle while busy is low.
// Backpressure: busy low at an edge gates the next byte; wr_ready drops when the word FIFO is full.
module iot_tx_serializer
    import iot_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_WORDS = 96,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        fn_cfg,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              busy,
    output logic              in_en,
    output logic [BYTE_W-1:0] iot_in,
    output logic [2:0]        fn_sel,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    tx_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [BYTE_W-1:0]  dat_q, dat_d;
    logic [2:0]         fn_q, fn_d;

    logic               pop;
    logic               avail;
    logic [WORD_W-1:0]  cur;
    logic               full, empty, has_two;
    logic [WORD_W-1:0]  head, head_next;

    iot_word_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_dat  (wr_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .has_two   (has_two),
        .head      (head),
        .head_next (head_next)
    );

    assign wr_ready = !full;
    assign in_en    = en_q;
    assign iot_in   = dat_q;
    assign fn_sel   = fn_q;
    assign sent_cnt = cnt_q;
    assign done     = (state_q == TX_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            dat_q   <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dat_q   <= dat_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        dat_d   = '0;
        fn_d    = fn_q;
        pop     = 1'b0;
        avail   = 1'b0;
        cur     = head;

        case (state_q)
            TX_IDLE, TX_DONE: begin
                if (start) begin
                    fn_d    = fn_cfg;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                // A byte on the bus is always consumed at this edge, busy or not.
                if (en_q) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        pop   = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Decide the next byte against the FIFO as it will look after this pop.
                avail = pop ? has_two : !empty;
                cur   = pop ? head_next : head;
                if (cnt_d == LAST_CNT) begin
                    state_d = TX_DONE;
                end else if (!busy && avail) begin
                    en_d  = 1'b1;
                    dat_d = word_byte(cur, idx_d);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_iot_tx_serializer.sv
// Randomized bench for iot_tx_serializer: byte streams are checked against a queue model of pushed words.
module tb_iot_tx_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   fn_cfg = 3'd0;
    logic         wr_valid = 1'b0;
    logic [127:0] wr_data = '0;
    logic         wr_ready;
    logic         busy = 1'b0;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [6:0]   sent_cnt;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] src[$];   // words the producer still has to offer
    logic [127:0] mdl[$];   // words accepted by the DUT, in order
    logic [7:0]   got[$];   // bytes consumed by the core, in order
    bit           busy_rand = 1'b0;
    int           busy_pct = 0;
    bit           busy_prev = 1'b0;

    iot_tx_serializer #(.DEPTH(4), .NUM_WORDS(96), .CNT_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fn_cfg   (fn_cfg),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .in_en    (in_en),
        .iot_in   (iot_in),
        .fn_sel   (fn_sel),
        .sent_cnt (sent_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(input logic [127:0] w, input int k);
        logic [127:0] s;
        s = w >> (8 * (15 - k));
        return s[7:0];
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock; entered and left #1 after a rising edge.
    task automatic cycle();
        bit push;
        @(negedge clk);
        push = rst && wr_valid && wr_ready;
        if (rst && in_en) got.push_back(iot_in);
        busy_prev = busy;
        @(posedge clk);
        #1;
        if (push) mdl.push_back(src.pop_front());
        start = 1'b0;
        wr_valid = (src.size() != 0);
        wr_data  = (src.size() != 0) ? src[0] : '0;
        if (busy_rand) busy = ($urandom_range(99) < busy_pct);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; wr_valid = 1'b0; busy = 1'b0; busy_rand = 1'b0;
        src.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mdl.delete();
        got.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (in_en !== 1'b0)   begin n_err++; $display("FAIL reset_in_en: got %b want 0", in_en); end
        n_cmp++; if (iot_in !== 8'h00) begin n_err++; $display("FAIL reset_iot_in: got %h want 00", iot_in); end
        n_cmp++; if (fn_sel !== 3'd0)  begin n_err++; $display("FAIL reset_fn_sel: got %0d want 0", fn_sel); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (sent_cnt !== 7'd0) begin n_err++; $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_single_word();
        logic [127:0] w;
        bit ok;
        do_reset();
        w = 128'h00112233445566778899AABBCCDDEEFF;
        src.push_back(w);
        cycle(); cycle();
        start = 1'b1; fn_cfg = 3'd3;
        cycle();
        n_cmp++; if (fn_sel !== 3'd3) begin n_err++; $display("FAIL single_fn_sel: got %0d want 3", fn_sel); end
        n_cmp++; if (in_en !== 1'b0)  begin n_err++; $display("FAIL single_latency: in_en %b after start edge, want 0", in_en); end
        cycle();
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (in_en !== 1'b1 || iot_in !== byte_of(w, k)) begin
                ok = 1'b0;
                $display("FAIL single_byte%0d: got en=%b %h want en=1 %h", k, in_en, iot_in, byte_of(w, k));
            end
            cycle();
        end
        n_cmp++; if (!ok) n_err++;
        n_cmp++; if (sent_cnt !== 7'd1) begin n_err++; $display("FAIL single_sent_cnt: got %0d want 1", sent_cnt); end
        n_cmp++; if (in_en !== 1'b0)    begin n_err++; $display("FAIL single_idle_after: in_en %b want 0", in_en); end
    endtask

    task automatic test_backpressure();
        logic [127:0] w;
        int bad;
        do_reset();
        w = rand_word();
        src.push_back(w);
        cycle(); cycle();
        start = 1'b1; fn_cfg = 3'd1;
        cycle();
        repeat (6) cycle();
        n_cmp++; if (in_en !== 1'b1 || iot_in !== byte_of(w, 5)) begin
            n_err++; $display("FAIL bp_byte5: got en=%b %h want en=1 %h", in_en, iot_in, byte_of(w, 5));
        end
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d: in_en %b want 0", i, in_en); end
        end
        busy = 1'b0;
        cycle();
        n_cmp++; if (in_en !== 1'b1 || iot_in !== byte_of(w, 6)) begin
            n_err++; $display("FAIL bp_resume: got en=%b %h want en=1 %h", in_en, iot_in, byte_of(w, 6));
        end
        repeat (12) cycle();
        bad = 0;
        for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== byte_of(w, i)) bad++;
        n_cmp++; if (got.size() != 16 || bad != 0) begin
            n_err++; $display("FAIL bp_stream: got %0d bytes (%0d wrong) want 16", got.size(), bad);
        end
        n_cmp++; if (sent_cnt !== 7'd1) begin n_err++; $display("FAIL bp_sent_cnt: got %0d want 1", sent_cnt); end
    endtask

    task automatic test_fifo_full();
        int bad;
        int c;
        do_reset();
        for (int i = 0; i < 5; i++) src.push_back(rand_word());
        c = 0;
        while (mdl.size() < 4 && c < 20) begin cycle(); c++; end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready: got %b want 0 after 4 pushes", wr_ready); end
        cycle(); cycle();
        n_cmp++; if (src.size() != 1 || wr_ready !== 1'b0) begin
            n_err++; $display("FAIL full_hold: %0d words pending, wr_ready %b; want 1 pending, 0", src.size(), wr_ready);
        end
        start = 1'b1; fn_cfg = 3'd4;
        cycle();
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (wr_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_early_ready: wr_ready high %0d cycles, want 0", bad); end
        cycle();
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL full_release: wr_ready %b want 1 after last byte", wr_ready); end
        cycle();
        n_cmp++; if (mdl.size() != 5) begin n_err++; $display("FAIL full_fifth_push: %0d words accepted want 5", mdl.size()); end
        busy_rand = 1'b1; busy_pct = 30;
        c = 0;
        while (got.size() < 80 && c < 2000) begin cycle(); c++; end
        bad = 0;
        for (int i = 0; i < got.size() && i / 16 < mdl.size(); i++) if (got[i] !== byte_of(mdl[i / 16], i % 16)) bad++;
        n_cmp++; if (got.size() != 80 || bad != 0) begin
            n_err++; $display("FAIL full_stream: got %0d bytes (%0d wrong) want 80", got.size(), bad);
        end
        n_cmp++; if (sent_cnt !== 7'd5) begin n_err++; $display("FAIL full_sent_cnt: got %0d want 5", sent_cnt); end
    endtask

    task automatic test_frame_end();
        logic [2:0] fc;
        int bad;
        int bviol;
        bit fin;
        do_reset();
        for (int i = 0; i < 100; i++) src.push_back(rand_word());
        fc = 3'($urandom_range(1, 7));
        busy_rand = 1'b1; busy_pct = 30;
        start = 1'b1; fn_cfg = fc;
        cycle();
        fin = 1'b0; bviol = 0;
        for (int c = 0; c < 8000 && !fin; c++) begin
            if (c == 200) begin start = 1'b1; fn_cfg = ~fc; end
            cycle();
            if (in_en === 1'b1 && busy_prev) bviol++;
            if (c == 200) begin
                n_cmp++; if (fn_sel !== fc) begin n_err++; $display("FAIL frame_start_in_send: fn_sel %0d want %0d", fn_sel, fc); end
            end
            fin = (done === 1'b1);
        end
        n_cmp++; if (!fin) begin n_err++; $display("FAIL frame_timeout: done %b want 1 within budget", done); end
        n_cmp++; if (bviol != 0) begin n_err++; $display("FAIL frame_busy: %0d bytes issued after busy edge, want 0", bviol); end
        bad = 0;
        for (int i = 0; i < got.size() && i / 16 < mdl.size(); i++) if (got[i] !== byte_of(mdl[i / 16], i % 16)) bad++;
        n_cmp++; if (got.size() != 1536 || bad != 0) begin
            n_err++; $display("FAIL frame_stream: got %0d bytes (%0d wrong) want 1536", got.size(), bad);
        end
        n_cmp++; if (sent_cnt !== 7'd96) begin n_err++; $display("FAIL frame_sent_cnt: got %0d want 96", sent_cnt); end
        n_cmp++; if (in_en !== 1'b0)     begin n_err++; $display("FAIL frame_in_en: got %b want 0", in_en); end
        busy_rand = 1'b0; busy = 1'b0;
        cycle(); cycle();
        n_cmp++; if (done !== 1'b1 || mdl.size() != 100) begin
            n_err++; $display("FAIL frame_done_hold: done %b, %0d words accepted; want 1, 100", done, mdl.size());
        end
        got.delete();
        start = 1'b1; fn_cfg = 3'd6;
        cycle();
        n_cmp++; if (fn_sel !== 3'd6) begin n_err++; $display("FAIL frame2_fn_sel: got %0d want 6", fn_sel); end
        repeat (70) cycle();
        bad = 0;
        for (int i = 0; i < got.size() && 96 + i / 16 < mdl.size(); i++) if (got[i] !== byte_of(mdl[96 + i / 16], i % 16)) bad++;
        n_cmp++; if (got.size() != 64 || bad != 0) begin
            n_err++; $display("FAIL frame2_stream: got %0d bytes (%0d wrong) want 64", got.size(), bad);
        end
        n_cmp++; if (sent_cnt !== 7'd4 || done !== 1'b0) begin
            n_err++; $display("FAIL frame2_cnt: sent_cnt %0d done %b want 4, 0", sent_cnt, done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] w;
        int bad;
        bit fin;
        do_reset();
        for (int i = 0; i < 20; i++) src.push_back(rand_word());
        start = 1'b1; fn_cfg = 3'd2;
        cycle();
        fin = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            cycle();
            fin = (got.size() == 167);
        end
        n_cmp++; if (!fin || mdl.size() < 11 || in_en !== 1'b1 || iot_in !== byte_of(mdl[10], 7)) begin
            n_err++; $display("FAIL mid_position: reached %b en=%b byte %h, want word10 byte7 on bus", fin, in_en, iot_in);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_en !== 1'b0 || iot_in !== 8'h00) begin
            n_err++; $display("FAIL mid_async_bus: en=%b %h want 0 00", in_en, iot_in);
        end
        n_cmp++; if (sent_cnt !== 7'd0 || fn_sel !== 3'd0 || done !== 1'b0 || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_async_state: cnt %0d fn %0d done %b rdy %b want 0 0 0 1", sent_cnt, fn_sel, done, wr_ready);
        end
        wr_valid = 1'b0; src.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mdl.delete(); got.delete();
        w = rand_word();
        src.push_back(w);
        cycle(); cycle();
        start = 1'b1; fn_cfg = 3'd5;
        cycle();
        n_cmp++; if (sent_cnt !== 7'd0) begin n_err++; $display("FAIL mid_restart_cnt: got %0d want 0", sent_cnt); end
        cycle();
        n_cmp++; if (in_en !== 1'b1 || iot_in !== byte_of(w, 0)) begin
            n_err++; $display("FAIL mid_restart_first: en=%b %h want en=1 %h", in_en, iot_in, byte_of(w, 0));
        end
        repeat (17) cycle();
        bad = 0;
        for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== byte_of(w, i)) bad++;
        n_cmp++; if (got.size() != 16 || bad != 0 || sent_cnt !== 7'd1) begin
            n_err++; $display("FAIL mid_restart_stream: %0d bytes (%0d wrong) cnt %0d want 16, 0, 1", got.size(), bad, sent_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_fifo_full();
        test_frame_end();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
